// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine front panel and controller:
// program codes, panel state encoding and default conditioning parameters.
package wm_pkg;

    localparam int unsigned PROG_W = 3;

    localparam logic [PROG_W-1:0] COLD_WASH   = 3'd0;
    localparam logic [PROG_W-1:0] HOT_WASH    = 3'd1;
    localparam logic [PROG_W-1:0] RINSING_DRY = 3'd2;
    localparam logic [PROG_W-1:0] ONLY_DRY    = 3'd3;
    localparam logic [PROG_W-1:0] WARM_WASH   = 3'd4;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        SEL     = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        DONE    = 2'd3
    } panel_state_e;

    // Step to the next program code, wrapping after the last valid one.
    function automatic logic [PROG_W-1:0] next_program(input logic [PROG_W-1:0] cur,
                                                       input int unsigned       num);
        if (32'(cur) + 32'd1 >= num) begin
            return '0;
        end
        return cur + 3'd1;
    endfunction

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; flags the cycle
// in which the debounced level is about to rise or fall.
module wm_debounce
    import wm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Pulses are aligned with the edge that updates db_q, so consumers that
    // register them act on the same edge the debounced level changes.
    assign rise_o = db_d & ~db_q;
    assign fall_o = ~db_d & db_q;
    assign db_o   = db_q;

endmodule

// File: rtl/wm_control_panel.sv
// Front-panel input stage: conditions buttons and sensors, selects the program
// and handshakes start/lockDoor/program_done with the controller FSM.
module wm_control_panel
    import wm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned ARM_TIMEOUT     = 8,
    parameter int unsigned NUM_PROGRAMS    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              btn_prog_raw,
    input  logic              btn_start_raw,
    input  logic              door_raw,
    input  logic              soap_raw,
    input  logic              lockDoor,
    input  logic              program_done,
    output logic [PROG_W-1:0] program_selection,
    output logic              start,
    output logic              doorclosed,
    output logic              soap,
    output logic              door_warning,
    output logic              busy,
    output logic              done_led
);

    localparam int unsigned TmoW = $clog2(ARM_TIMEOUT + 1);

    logic prog_ev;
    logic start_ev;
    logic door_db;
    logic door_rise;
    logic door_fall;
    logic soap_db;
    logic unused_prog_db;
    logic unused_prog_fall;
    logic unused_start_db;
    logic unused_start_fall;
    logic unused_soap_rise;
    logic unused_soap_fall;

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (btn_prog_raw),
        .db_o   (unused_prog_db),
        .rise_o (prog_ev),
        .fall_o (unused_prog_fall)
    );

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (btn_start_raw),
        .db_o   (unused_start_db),
        .rise_o (start_ev),
        .fall_o (unused_start_fall)
    );

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (door_raw),
        .db_o   (door_db),
        .rise_o (door_rise),
        .fall_o (door_fall)
    );

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soap (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (soap_raw),
        .db_o   (soap_db),
        .rise_o (unused_soap_rise),
        .fall_o (unused_soap_fall)
    );

    panel_state_e      state_q, state_d;
    logic [PROG_W-1:0] sel_q, sel_d;
    logic              start_q, start_d;
    logic              warn_q, warn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEL;
            sel_q   <= COLD_WASH;
            start_q <= 1'b0;
            warn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            warn_q  <= warn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        start_d = start_q;
        warn_d  = warn_q;
        tmo_d   = '0;

        if (door_rise) begin
            warn_d = 1'b0;
        end

        if (!power) begin
            state_d = SEL;
            start_d = 1'b0;
            warn_d  = 1'b0;
        end else begin
            unique case (state_q)
                SEL: begin
                    // start wins over a simultaneous program press
                    if (start_ev) begin
                        if (door_db) begin
                            state_d = ARMED;
                            start_d = 1'b1;
                        end else begin
                            warn_d = 1'b1;
                        end
                    end else if (prog_ev) begin
                        sel_d  = next_program(sel_q, NUM_PROGRAMS);
                        warn_d = 1'b0;
                    end
                end
                ARMED: begin
                    start_d = 1'b1;
                    if (lockDoor) begin
                        state_d = RUNNING;
                        start_d = 1'b0;
                    end else if (!door_db) begin
                        state_d = SEL;
                        start_d = 1'b0;
                        warn_d  = 1'b1;
                    end else if (tmo_q + TmoW'(1) == TmoW'(ARM_TIMEOUT)) begin
                        state_d = SEL;
                        start_d = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
                RUNNING: begin
                    if (program_done) begin
                        state_d = DONE;
                    end else if (!lockDoor) begin
                        state_d = SEL;
                    end
                end
                DONE: begin
                    // the waking event is swallowed here, not replayed in SEL
                    if (prog_ev || start_ev || door_fall) begin
                        state_d = SEL;
                    end
                end
                default: state_d = SEL;
            endcase
        end

        busy_d = (state_d == RUNNING);
        done_d = (state_d == DONE);
    end

    assign program_selection = sel_q;
    assign start             = start_q;
    assign doorclosed        = door_db;
    assign soap              = soap_db;
    assign door_warning      = warn_q;
    assign busy              = busy_q;
    assign done_led          = done_q;

endmodule
